out_axis_arbiter: RTL and testbench
===================================

// Module: out_axis_arbiter
// PURPOSE
// - Egress scheduler ahead of the AXI-Stream master port: shares one m_axis output between NUM_SRC pipeline outputs.
// - Sources have no backpressure; each gets a small FIFO.
// - Packet-granular round-robin arbitration, grant held until the last beat.
// - Registered output stage with full valid/ready handshake.
// PARAMETERS
// - DATA_W      1024        beat width
// - KEEP_W      DATA_W/8    tkeep width
// - NUM_SRC     2           number of sources, 2..8
// - FIFO_DEPTH  4           beats per source FIFO, power of 2, >=2
// PORTS
// - axis_aclk      in   1               single clock, all logic rising edge
// - axis_aresetn   in   1               asynchronous, active-low reset
// - src_en         in   NUM_SRC         per-source beat strobe; no ready
// - src_data       in   NUM_SRC*DATA_W  per-source beat data, source i at [i*DATA_W +: DATA_W]
// - src_last       in   NUM_SRC         per-source end-of-packet flag
// - ovf_clr        in   1               pulse: clears all ovf_flag bits
// - ovf_flag       out  NUM_SRC         sticky: beat dropped on full FIFO
// - m_axis_tvalid  out  1
// - m_axis_tready  in   1
// - m_axis_tdata   out  DATA_W
// - m_axis_tkeep   out  KEEP_W
// - m_axis_tlast   out  1
// - stat_pkts      out  NUM_SRC*32      packets forwarded per source
// - stat_drops     out  NUM_SRC*32      beats dropped per source
// BEHAVIOUR
// - Reset values (async, any cycle, including mid-packet):
//   - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
//   - ovf_flag=0, FIFOs empty, FSM=IDLE, rr_ptr=0.
//   - Any partial packet is discarded.
// - Enqueue:
//   - src_en[i] high and FIFO i not full: write {data,last}.
//   - src_en[i] high and FIFO i full: drop the beat; set ovf_flag[i] next cycle.
//   - A beat written in cycle N is poppable in cycle N+1 (no bypass).
// - Output stage (one register):
//   - Loads when empty or (m_axis_tvalid & m_axis_tready) in the same cycle; load_ok = either condition.
//   - Holds tdata, tkeep and tlast stable while tvalid & !tready; tvalid never drops without a handshake.
//   - tkeep = all ones when valid, 0 when idle.
// - FSM {IDLE, BUSY}:
//   - IDLE: winner = first non-empty source starting at rr_ptr, ascending, modulo NUM_SRC. Combinational grant.
//   - IDLE: if load_ok, pop the winner this cycle and set rr_ptr = winner+1 (wraps).
//   - IDLE: if the popped beat has last=0, go to BUSY holding grant=winner.
//   - BUSY: pop the granted source whenever load_ok and its FIFO is non-empty; other sources wait.
//   - BUSY: go to IDLE on the cycle a last=1 beat is popped.
//   - BUSY with the granted FIFO empty: stall, keep the grant; no interleaving ever.
// - Throughput and latency:
//   - Sustains 1 beat/cycle with tready=1.
//   - Back-to-back single-beat packets from different sources alternate with no bubble.
//   - Latency src_en to m_axis_tvalid = 2 cycles with the output stage empty.
// - Simultaneous events:
//   - Push and pop on the same FIFO in one cycle are both legal at full or empty.
//   - A full FIFO being popped still drops the incoming beat (full is evaluated before the pop).
//   - ovf_clr and a new drop in the same cycle: the flag ends set.
// CONFIGURATION
// - Macro OUT_ARB_STATS_EN.
// - Defined:
//   - stat_pkts[i] increments on each m_axis handshake with tlast from source i.
//   - stat_drops[i] increments on each dropped beat.
//   - Both are 32-bit, wrap to 0, reset to 0.
// - Undefined: stat_pkts and stat_drops are tied to 0; no counter logic is generated.
// STRUCTURE
// - Package out_arb_pkg: state_e {IDLE, BUSY}; function idx_w(n)=$clog2(n); STAT_W=32.
// - Sub-module out_arb_fifo: one per source, DATA_W+1 bits wide, FIFO_DEPTH deep.
//   - Pointers with an extra wrap bit; full and empty outputs.
// - Top level: generate loop of FIFOs, round-robin picker, FSM, output register, optional stats.
// TESTING
// 1. Reset: assert axis_aresetn=0 mid-packet. All outputs 0 asynchronously. After release, the first beat out is a fresh packet.
// 2. Single source: src 0 sends 1 beat 0xA5 with last=1, tready=1. m_axis_tvalid is high 2 cycles later with tdata=0xA5, tkeep all ones, tlast=1.
// 3. Round robin: both sources send 3 single-beat packets in the same cycles. Output order is src0, src1, src0, src1, src0, src1 with no idle cycles.
// 4. Packet lock: src1 sends a 4-beat packet while src0 sends single beats. All 4 src1 beats are contiguous on m_axis and tlast is asserted only on beat 4.
// 5. Backpressure: tready=0 for 5 cycles while valid. tdata and tlast stay stable. No beat is lost or duplicated after tready=1.
// 6. Overflow: tready=0, src0 sends FIFO_DEPTH+2 beats. The last 2 beats are dropped and ovf_flag[0]=1. With OUT_ARB_STATS_EN, stat_drops[0]=2. ovf_clr clears the flag.

Source files
------------

// File: rtl/out_arb_pkg.sv
// Shared types and helpers for the egress AXI-Stream arbiter.
package out_arb_pkg;

  localparam int STAT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/out_arb_fifo.sv
// Per-source beat FIFO: wrap-bit pointers, registered storage, no write-to-read bypass.
module out_arb_fifo
  import out_arb_pkg::*;
#(
  parameter int WIDTH = 1025,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = idx_w(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers only for operations the current fill level allows.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; clearing them empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless while empty so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/out_axis_arbiter.sv
// Egress scheduler: per-source FIFOs, packet-locked round-robin, registered
// AXI-Stream master stage. Optional counters enabled by macro OUT_ARB_STATS_EN.
module out_axis_arbiter
  import out_arb_pkg::*;
#(
  parameter int DATA_W     = 1024,
  parameter int KEEP_W     = DATA_W / 8,
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        axis_aclk,
  input  logic                        axis_aresetn,
  input  logic [NUM_SRC-1:0]          src_en,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_last,
  input  logic                        ovf_clr,
  output logic [NUM_SRC-1:0]          ovf_flag,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic [KEEP_W-1:0]           m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic [NUM_SRC*STAT_W-1:0]   stat_pkts,
  output logic [NUM_SRC*STAT_W-1:0]   stat_drops
);

  localparam int SEL_W = idx_w(NUM_SRC);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] fifo_pop;
  logic [NUM_SRC-1:0] drop;
  logic [DATA_W:0]    fifo_rdata [NUM_SRC];

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]   winner;
  logic               winner_vld;
  logic [SEL_W-1:0]   pop_sel;
  logic               pop_vld;
  logic [DATA_W:0]    sel_beat;
  logic               load_ok;

  logic               tvalid_q, tvalid_d;
  logic [DATA_W-1:0]  tdata_q, tdata_d;
  logic [KEEP_W-1:0]  tkeep_q, tkeep_d;
  logic               tlast_q, tlast_d;
  logic [NUM_SRC-1:0] ovf_q, ovf_d;

  assign drop    = src_en & fifo_full;
  assign load_ok = !tvalid_q || m_axis_tready;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
    assign fifo_pop[i] = pop_vld && (pop_sel == SEL_W'(i));

    out_arb_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (axis_aclk),
      .rst_ni  (axis_aresetn),
      .push_i  (src_en[i] && !fifo_full[i]),
      .wdata_i ({src_last[i], src_data[i*DATA_W +: DATA_W]}),
      .pop_i   (fifo_pop[i]),
      .rdata_o (fifo_rdata[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i])
    );
  end

  // Round-robin picker: first non-empty source at or after rr_ptr, wrapping.
  always_comb begin
    int cand;
    cand       = 0;
    winner     = rr_ptr_q;
    winner_vld = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_SRC) begin
        cand = cand - NUM_SRC;
      end
      if (!winner_vld && !fifo_empty[SEL_W'(cand)]) begin
        winner     = SEL_W'(cand);
        winner_vld = 1'b1;
      end
    end
  end

  // Grant FSM: IDLE picks a winner per packet, BUSY stays on it until tlast.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    pop_sel  = grant_q;
    pop_vld  = 1'b0;
    sel_beat = '0;
    case (state_q)
      IDLE: begin
        pop_sel  = winner;
        pop_vld  = winner_vld && load_ok;
        sel_beat = fifo_rdata[winner];
        if (pop_vld) begin
          rr_ptr_d = (winner == LAST_IDX) ? '0 : winner + 1'b1;
          grant_d  = winner;
          if (!sel_beat[DATA_W]) begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        pop_sel  = grant_q;
        pop_vld  = load_ok && !fifo_empty[grant_q];
        sel_beat = fifo_rdata[grant_q];
        if (pop_vld && sel_beat[DATA_W]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output stage: reload whenever empty or handshaking, otherwise hold steady.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    if (load_ok) begin
      tvalid_d = pop_vld;
      tdata_d  = pop_vld ? sel_beat[DATA_W-1:0] : '0;
      tkeep_d  = pop_vld ? '1 : '0;
      tlast_d  = pop_vld && sel_beat[DATA_W];
    end
  end

  // Sticky overflow flags; a same-cycle drop wins over a clear.
  assign ovf_d = (ovf_q & ~{NUM_SRC{ovf_clr}}) | drop;

  // Control and output registers; reset discards any packet in flight.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      ovf_q    <= ovf_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign ovf_flag      = ovf_q;

`ifdef OUT_ARB_STATS_EN
  logic [SEL_W-1:0] src_q;

  // Remember which source the beat sitting in the output stage came from.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      src_q <= '0;
    end else if (pop_vld) begin
      src_q <= pop_sel;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_stats
    logic [STAT_W-1:0] pkts_q;
    logic [STAT_W-1:0] drops_q;

    // Free-running wrap-around counters of forwarded packets and dropped beats.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
        pkts_q  <= '0;
        drops_q <= '0;
      end else begin
        if (tvalid_q && m_axis_tready && tlast_q && (src_q == SEL_W'(i))) begin
          pkts_q <= pkts_q + 1'b1;
        end
        if (drop[i]) begin
          drops_q <= drops_q + 1'b1;
        end
      end
    end

    assign stat_pkts[i*STAT_W +: STAT_W]  = pkts_q;
    assign stat_drops[i*STAT_W +: STAT_W] = drops_q;
  end
`else
  assign stat_pkts  = '0;
  assign stat_drops = '0;
`endif

endmodule

// File: tb/tb_out_axis_arbiter.sv
// Randomised and directed bench for out_axis_arbiter with a queue-based reference model.
module tb_out_axis_arbiter;

  localparam int DW    = 64;
  localparam int NS    = 2;
  localparam int DEPTH = 4;
  localparam int KW    = DW / 8;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic [NS-1:0]    srcEn = '0;
  logic [NS*DW-1:0] srcData = '0;
  logic [NS-1:0]    srcLast = '0;
  logic             ovfClr = 1'b0;
  logic             tready = 1'b0;
  logic [NS-1:0]    ovfFlag;
  logic             mValid;
  logic [DW-1:0]    mData;
  logic [KW-1:0]    mKeep;
  logic             mLast;
  logic [NS*32-1:0] statPkts;
  logic [NS*32-1:0] statDrops;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;
  int cycleCnt = 0;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } hs_t;

  beat_t         mq[NS][$];
  hs_t           hsQ[$];
  bit            mdValid = 1'b0;
  logic [DW-1:0] mdData = '0;
  bit            mdLast = 1'b0;
  int            mdSrc = 0;
  int            mdRr = 0;
  bit            mdLocked = 1'b0;
  int            mdLockSrc = 0;
  logic [NS-1:0] mdOvf = '0;
  int unsigned   mdPkts[NS];
  int unsigned   mdDrops[NS];

  out_axis_arbiter #(
    .DATA_W     (DW),
    .NUM_SRC    (NS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rstN),
    .src_en        (srcEn),
    .src_data      (srcData),
    .src_last      (srcLast),
    .ovf_clr       (ovfClr),
    .ovf_flag      (ovfFlag),
    .m_axis_tvalid (mValid),
    .m_axis_tready (tready),
    .m_axis_tdata  (mData),
    .m_axis_tkeep  (mKeep),
    .m_axis_tlast  (mLast),
    .stat_pkts     (statPkts),
    .stat_drops    (statDrops)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] tag(input int s, input int k);
    return {8'(s), 48'h0, 8'(k)};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NS; i++) begin
      mq[i].delete();
      mdPkts[i]  = 0;
      mdDrops[i] = 0;
    end
    mdValid  = 1'b0;
    mdData   = '0;
    mdLast   = 1'b0;
    mdSrc    = 0;
    mdRr     = 0;
    mdLocked = 1'b0;
    mdOvf    = '0;
  endtask

  // One clock of the reference: queues per source, packet lock, single output slot.
  task automatic modelStep();
    int    sel;
    bit    loadOk;
    bit    full[NS];
    beat_t b;
    sel = -1;
    if (mdValid && tready && mdLast) mdPkts[mdSrc]++;
    loadOk = !mdValid || tready;
    for (int i = 0; i < NS; i++) full[i] = (mq[i].size() == DEPTH);
    if (mdLocked) begin
      if (mq[mdLockSrc].size() > 0) sel = mdLockSrc;
    end else begin
      for (int k = 0; k < NS; k++) begin
        int c;
        c = (mdRr + k) % NS;
        if (sel < 0 && mq[c].size() > 0) sel = c;
      end
    end
    if (loadOk) begin
      if (sel >= 0) begin
        b = mq[sel].pop_front();
        mdValid = 1'b1;
        mdData  = b.data;
        mdLast  = b.last;
        mdSrc   = sel;
        if (!mdLocked) mdRr = (sel + 1) % NS;
        mdLocked  = !b.last;
        mdLockSrc = sel;
      end else begin
        mdValid = 1'b0;
        mdLast  = 1'b0;
      end
    end
    if (ovfClr) mdOvf = '0;
    for (int i = 0; i < NS; i++) begin
      if (srcEn[i]) begin
        if (full[i]) begin
          mdDrops[i]++;
          mdOvf[i] = 1'b1;
        end else begin
          mq[i].push_back({srcLast[i], srcData[i*DW +: DW]});
        end
      end
    end
  endtask

  // Reference model advances on the same edge as the DUT.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) modelReset();
    else modelStep();
  end

  // Record every completed handshake with its cycle number.
  always @(posedge clk) begin
    cycleCnt++;
    if (rstN && mValid && tready) hsQ.push_back('{data: mData, last: mLast, cyc: cycleCnt});
  end

  task automatic checkOutput();
    checkVal("tvalid", mValid, mdValid);
    checkVal("tkeep", mKeep, mdValid ? {KW{1'b1}} : '0);
    if (mdValid) begin
      checkVal("tdata", mData, mdData);
      checkVal("tlast", mLast, mdLast);
    end
    checkVal("ovf_flag", ovfFlag, mdOvf);
    for (int i = 0; i < NS; i++) begin
`ifdef OUT_ARB_STATS_EN
      checkVal("stat_pkts", statPkts[i*32 +: 32], mdPkts[i]);
      checkVal("stat_drops", statDrops[i*32 +: 32], mdDrops[i]);
`else
      checkVal("stat_pkts", statPkts[i*32 +: 32], 0);
      checkVal("stat_drops", statDrops[i*32 +: 32], 0);
`endif
    end
  endtask

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  task automatic applyStimulus(input logic [NS-1:0] en, input logic [NS-1:0] last,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic rdy, input logic clr);
    srcEn   = en;
    srcLast = last;
    srcData = {d1, d0};
    tready  = rdy;
    ovfClr  = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) applyStimulus('0, '0, '0, '0, rdy, 1'b0);
  endtask

  task automatic doReset();
    srcEn  = '0;
    ovfClr = 1'b0;
    rstN   = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    hsQ.delete();
  endtask

  initial begin
    int exp3[6];
    int expSrc4[8];
    int expLast4[8];
    logic [DW-1:0] exp6[5];

    #1 checkEn = 1'b1;
    repeat (2) @(negedge clk);
    checkVal("rst_tvalid", mValid, 0);
    checkVal("rst_tkeep", mKeep, 0);
    checkVal("rst_tdata", mData, 0);
    checkVal("rst_ovf", ovfFlag, 0);
    rstN = 1'b1;

    // Mid-packet asynchronous reset discards the partial packet.
    for (int k = 0; k < 3; k++) applyStimulus(2'b01, 2'b00, tag(0, 16 + k), '0, 1'b1, 1'b0);
    srcEn = '0;
    #2 rstN = 1'b0;
    #1;
    checkVal("t1_tvalid", mValid, 0);
    checkVal("t1_tdata", mData, 0);
    checkVal("t1_tlast", mLast, 0);
    checkVal("t1_tkeep", mKeep, 0);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    hsQ.delete();
    applyStimulus(2'b01, 2'b01, 64'hB7, '0, 1'b1, 1'b0);
    idle(4, 1'b1);
    checkVal("t1_count", hsQ.size(), 1);
    if (hsQ.size() > 0) begin
      checkVal("t1_data", hsQ[0].data, 64'hB7);
      checkVal("t1_last", hsQ[0].last, 1);
    end

    // Single beat latency.
    doReset();
    applyStimulus(2'b01, 2'b01, 64'hA5, '0, 1'b1, 1'b0);
    checkVal("t2_early_tvalid", mValid, 0);
    applyStimulus('0, '0, '0, '0, 1'b1, 1'b0);
    checkVal("t2_tvalid", mValid, 1);
    checkVal("t2_tdata", mData, 64'hA5);
    checkVal("t2_tkeep", mKeep, {KW{1'b1}});
    checkVal("t2_tlast", mLast, 1);
    idle(3, 1'b1);

    // Round robin between simultaneous single-beat packets.
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(2'b11, 2'b11, tag(0, k), tag(1, k), 1'b1, 1'b0);
    idle(8, 1'b1);
    exp3 = '{0, 1, 0, 1, 0, 1};
    checkVal("t3_count", hsQ.size(), 6);
    if (hsQ.size() == 6) begin
      for (int j = 0; j < 6; j++) begin
        checkVal("t3_src", hsQ[j].data[63:56], exp3[j]);
        checkVal("t3_gap", hsQ[j].cyc - hsQ[0].cyc, j);
      end
    end

    // Packet lock: 4-beat src1 packet stays contiguous.
    doReset();
    for (int k = 0; k < 4; k++) applyStimulus(2'b11, {k == 3, 1'b1}, tag(0, k), tag(1, k), 1'b1, 1'b0);
    idle(10, 1'b1);
    expSrc4  = '{0, 1, 1, 1, 1, 0, 0, 0};
    expLast4 = '{1, 0, 0, 0, 1, 1, 1, 1};
    checkVal("t4_count", hsQ.size(), 8);
    if (hsQ.size() == 8) begin
      for (int j = 0; j < 8; j++) begin
        checkVal("t4_src", hsQ[j].data[63:56], expSrc4[j]);
        checkVal("t4_last", hsQ[j].last, expLast4[j]);
      end
    end

    // Backpressure holds the output stable.
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(2'b01, {1'b0, k == 2}, tag(0, 32 + k), '0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      checkVal("t5_hold_valid", mValid, 1);
      checkVal("t5_hold_data", mData, tag(0, 32));
      checkVal("t5_hold_last", mLast, 0);
      idle(1, 1'b0);
    end
    idle(6, 1'b1);
    checkVal("t5_count", hsQ.size(), 3);
    if (hsQ.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        checkVal("t5_data", hsQ[j].data, tag(0, 32 + j));
        checkVal("t5_last", hsQ[j].last, j == 2);
      end
    end

    // Overflow: output stage and FIFO full, last two beats dropped.
    doReset();
    applyStimulus(2'b01, 2'b01, 64'hF0, '0, 1'b0, 1'b0);
    idle(2, 1'b0);
    for (int k = 0; k < DEPTH + 2; k++) applyStimulus(2'b01, 2'b01, 64'hE0 + 64'(k), '0, 1'b0, 1'b0);
    idle(1, 1'b0);
    checkVal("t6_ovf", ovfFlag, 2'b01);
`ifdef OUT_ARB_STATS_EN
    checkVal("t6_drops", statDrops[31:0], 2);
`endif
    idle(8, 1'b1);
    exp6 = '{64'hF0, 64'hE0, 64'hE1, 64'hE2, 64'hE3};
    checkVal("t6_count", hsQ.size(), 5);
    if (hsQ.size() == 5) begin
      for (int j = 0; j < 5; j++) checkVal("t6_data", hsQ[j].data, exp6[j]);
    end
    applyStimulus('0, '0, '0, '0, 1'b1, 1'b1);
    checkVal("t6_clr", ovfFlag, 2'b00);

    // Random traffic against the model.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      logic [NS-1:0] en;
      logic [NS-1:0] last;
      for (int i = 0; i < NS; i++) begin
        en[i]   = ($urandom_range(0, 99) < 55);
        last[i] = ($urandom_range(0, 2) == 0);
      end
      applyStimulus(en, last, {$urandom, $urandom}, {$urandom, $urandom},
                    ($urandom_range(0, 99) < 60), ($urandom_range(0, 49) == 0));
    end
    idle(20, 1'b1);

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
